grdmac_mem_burst: RTL and testbench

//  Burst initiator for the GRDMAC scratch memory wrapper. Accepts one command
//  (address, length, direction) and then either streams words from the write

---
 rtl/grdmac_mem_burst.sv | 196 +++++++++++++++++++
 tb/tb_grdmac_mem_burst.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/grdmac_mem_burst.sv
// Burst initiator between the GRDMAC channel engine and the scratch SRAM wrapper.
// Latency: writes go to the SRAM in the same cycle as the wr handshake; reads issue one
//          cycle after the command and reach rd_valid two cycles after the issue.
// Backpressure: wr_ready_o is high for the whole write burst. Read issue is throttled so
//               that buffered plus in-flight words never exceed the 2-entry skid FIFO.
//
// Ports:
//   clk_i, rstn_i         clock, asynchronous active-low reset
//   cmd_*                 valid/ready command: write direction, start address, length-1
//   wr_*                  valid/ready write-data stream into the SRAM
//   rd_*                  valid/ready read-data stream out of the SRAM, rd_last_o marks the last word
//   busy_o, done_o        burst in progress / one-cycle completion pulse
//   mem_*                 wrapper pins (address, datain, byte enable, byte write, dataout)
module grdmac_mem_burst #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [ADDR_WIDTH-1:0] cmd_len_i,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_last_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] mem_address_o,
    output logic [DATA_WIDTH-1:0] mem_datain_o,
    output logic [3:0]            mem_enable_o,
    output logic [3:0]            mem_write_o,
    input  logic [DATA_WIDTH-1:0] mem_dataout_i
);

    localparam int CW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    // Words still to be written (WRITE) or popped (READ), minus one.
    logic [ADDR_WIDTH-1:0] rem_q, rem_d;
    // Read accesses not yet issued to the SRAM; needs one extra bit for a full 2**AW burst.
    logic [CW-1:0]         iss_q, iss_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            buf_cnt_q, buf_cnt_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic                  done_q, done_d;

    logic       wr_fire;
    logic       rd_issue;
    logic       pop;
    logic [2:0] occ;

    assign wr_fire = (state_q == S_WRITE) && wr_valid_i;
    assign pop     = (state_q == S_READ) && (buf_cnt_q != 2'd0) && rd_ready_i;
    assign occ     = {1'b0, buf_cnt_q} + {2'b00, inflight_q};
    // Issue only if the word can still land in the FIFO: (occ - pop) < 2.
    assign rd_issue = (state_q == S_READ) && (iss_q != '0) &&
                      (occ < (3'd2 + {2'b00, pop}));

    assign cmd_ready_o   = (state_q == S_IDLE);
    assign wr_ready_o    = (state_q == S_WRITE);
    assign rd_valid_o    = (buf_cnt_q != 2'd0);
    assign rd_data_o     = head_q;
    assign rd_last_o     = (buf_cnt_q != 2'd0) && (rem_q == '0);
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = done_q;
    // Driven straight from state_q, so reset forces the enables low without waiting for a clock.
    assign mem_enable_o  = (wr_fire || rd_issue) ? 4'hF : 4'h0;
    assign mem_write_o   = wr_fire ? 4'hF : 4'h0;
    assign mem_address_o = (state_q != S_IDLE) ? ptr_q : '0;
    assign mem_datain_o  = wr_fire ? wr_data_i : '0;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rem_d      = rem_q;
        iss_d      = iss_q;
        inflight_d = rd_issue;
        buf_cnt_d  = buf_cnt_q;
        head_d     = head_q;
        tail_d     = tail_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    ptr_d = cmd_addr_i;
                    rem_d = cmd_len_i;
                    if (cmd_write_i) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                        iss_d   = {1'b0, cmd_len_i} + CW'(1);
                    end
                end
            end
            S_WRITE: begin
                if (wr_valid_i) begin
                    ptr_d = ptr_q + ADDR_WIDTH'(1);
                    rem_d = rem_q - ADDR_WIDTH'(1);
                    if (rem_q == '0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_READ: begin
                if (rd_issue) begin
                    ptr_d = ptr_q + ADDR_WIDTH'(1);
                    iss_d = iss_q - CW'(1);
                end
                if (pop) begin
                    rem_d = rem_q - ADDR_WIDTH'(1);
                    if (rem_q == '0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Two-entry FIFO; push is the SRAM word for last cycle's issue.
        // The head is zeroed when the FIFO drains so rd_data_o idles at 0.
        case (buf_cnt_q)
            2'd0: begin
                if (inflight_q) begin
                    head_d    = mem_dataout_i;
                    buf_cnt_d = 2'd1;
                end
            end
            2'd1: begin
                if (pop && inflight_q) begin
                    head_d = mem_dataout_i;
                end else if (pop) begin
                    head_d    = '0;
                    buf_cnt_d = 2'd0;
                end else if (inflight_q) begin
                    tail_d    = mem_dataout_i;
                    buf_cnt_d = 2'd2;
                end
            end
            2'd2: begin
                // The issue throttle guarantees no push here unless a pop frees a slot.
                if (pop) begin
                    head_d = tail_q;
                    if (inflight_q) begin
                        tail_d = mem_dataout_i;
                    end else begin
                        tail_d    = '0;
                        buf_cnt_d = 2'd1;
                    end
                end
            end
            default: buf_cnt_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            rem_q      <= '0;
            iss_q      <= '0;
            inflight_q <= 1'b0;
            buf_cnt_q  <= 2'd0;
            head_q     <= '0;
            tail_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            iss_q      <= iss_d;
            inflight_q <= inflight_d;
            buf_cnt_q  <= buf_cnt_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_grdmac_mem_burst.sv
module tb_grdmac_mem_burst;

    logic        clk;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [7:0]  cmd_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic        rd_last;
    logic        busy;
    logic        done;
    logic [7:0]  mem_address;
    logic [31:0] mem_datain;
    logic [3:0]  mem_enable;
    logic [3:0]  mem_write;
    logic [31:0] mem_dataout;

    int checks = 0;
    int errors = 0;
    int iss_tot = 0;
    int pop_tot = 0;
    int wr_tot = 0;

    logic [31:0] sram    [256];
    logic [31:0] ref_mem [256];

    grdmac_mem_burst #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_write_i  (cmd_write),
        .cmd_addr_i   (cmd_addr),
        .cmd_len_i    (cmd_len),
        .wr_valid_i   (wr_valid),
        .wr_ready_o   (wr_ready),
        .wr_data_i    (wr_data),
        .rd_valid_o   (rd_valid),
        .rd_ready_i   (rd_ready),
        .rd_data_o    (rd_data),
        .rd_last_o    (rd_last),
        .busy_o       (busy),
        .done_o       (done),
        .mem_address_o(mem_address),
        .mem_datain_o (mem_datain),
        .mem_enable_o (mem_enable),
        .mem_write_o  (mem_write),
        .mem_dataout_i(mem_dataout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM wrapper model: synchronous write, read data valid the cycle after the access.
    always @(posedge clk) begin
        if (mem_enable == 4'hF) begin
            if (mem_write == 4'hF) begin
                sram[mem_address] <= mem_datain;
                wr_tot = wr_tot + 1;
            end else begin
                mem_dataout <= sram[mem_address];
                iss_tot = iss_tot + 1;
            end
        end
        if (rstn && rd_valid && rd_ready) pop_tot = pop_tot + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({pfx, "_wr_ready"}, 32'(wr_ready), 32'd0);
        check({pfx, "_rd_valid"}, 32'(rd_valid), 32'd0);
        check({pfx, "_rd_last"}, 32'(rd_last), 32'd0);
        check({pfx, "_busy"}, 32'(busy), 32'd0);
        check({pfx, "_done"}, 32'(done), 32'd0);
        check({pfx, "_rd_data"}, rd_data, 32'd0);
        check({pfx, "_mem_en_wr"}, 32'({mem_enable, mem_write}), 32'd0);
        check({pfx, "_mem_address"}, 32'(mem_address), 32'd0);
        check({pfx, "_mem_datain"}, mem_datain, 32'd0);
    endtask

    // Entered and left at the drive phase (#1 after a rising edge).
    // On return the command handshake has happened; the current cycle is burst cycle 1.
    task automatic do_cmd(input logic w, input logic [7:0] a, input logic [7:0] l);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = l;
        @(negedge clk);
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic write_burst(input logic [7:0] a, input logic [7:0] l, input logic [31:0] base);
        logic [7:0] ea;
        do_cmd(1'b1, a, l);
        for (int i = 0; i <= int'(l); i++) begin
            ea       = 8'(a + 8'(i));
            wr_valid = 1'b1;
            wr_data  = base + 32'(i);
            ref_mem[ea] = base + 32'(i);
            @(negedge clk);
            check("wr_en_wr", 32'({mem_enable, mem_write}), 32'h0000_00FF);
            check("wr_address", 32'(mem_address), 32'(ea));
            check("wr_datain", mem_datain, base + 32'(i));
            check("wr_ready", 32'(wr_ready), 32'd1);
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        @(negedge clk);
        check("wr_done", 32'(done), 32'd1);
        check("wr_busy_end", 32'(busy), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("wr_done_pulse", 32'(done), 32'd0);
        @(posedge clk); #1;
    endtask

    // mode 0: rd_ready held high; mode 1: rd_ready pattern 1,0,0 repeating.
    task automatic read_burst(input logic [7:0] a, input logic [7:0] l, input int mode);
        int cyc, k, first_v, last_pop, done_cyc, iss0, pop0, outst, max_out;
        iss0 = iss_tot;
        pop0 = pop_tot;
        do_cmd(1'b0, a, l);
        cyc = 1; k = 0; first_v = -1; last_pop = -1; done_cyc = -1; max_out = 0;
        while (done_cyc < 0 && cyc < 200) begin
            rd_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 1);
            @(negedge clk);
            if (rd_valid) begin
                if (first_v < 0) first_v = cyc;
                check("rd_data", rd_data, ref_mem[8'(a + 8'(k))]);
                check("rd_last", 32'(rd_last), 32'(k == int'(l)));
                if (rd_ready) begin
                    last_pop = cyc;
                    k++;
                end
            end
            if (done) done_cyc = cyc;
            outst = (iss_tot - iss0) - (pop_tot - pop0);
            if (outst > max_out) max_out = outst;
            @(posedge clk); #1;
            cyc++;
        end
        rd_ready = 1'b0;
        check("rd_word_count", 32'(k), 32'(int'(l) + 1));
        check("rd_issue_count", 32'(iss_tot - iss0), 32'(int'(l) + 1));
        check("rd_outstanding_le2", 32'(max_out <= 2), 32'd1);
        check("rd_done_after_last", 32'(done_cyc), 32'(last_pop + 1));
        if (mode == 0) begin
            check("rd_first_valid_cycle", 32'(first_v), 32'd3);
            check("rd_last_pop_cycle", 32'(last_pop), 32'(3 + int'(l)));
        end
        @(negedge clk);
        check("rd_done_pulse", 32'(done), 32'd0);
        check("rd_idle_valid", 32'(rd_valid), 32'd0);
        check("rd_idle_data", rd_data, 32'd0);
        check("rd_idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0;
        rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;

        // Reset state
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        // 1. Write burst 0x10..0x13, 2. readback with rd_ready high
        write_burst(8'h10, 8'd3, 32'hA000_0000);
        read_burst(8'h10, 8'd3, 0);

        // 3. Address wrap 0xFE,0xFF,0x00,0x01
        write_burst(8'hFE, 8'd3, 32'hB000_0000);
        read_burst(8'hFE, 8'd3, 0);

        // 4. Backpressure on an 8-word read
        write_burst(8'h20, 8'd7, 32'hC000_0000);
        read_burst(8'h20, 8'd7, 1);

        // 5. Single word with wr_valid only in cycle 5; a command during busy is ignored
        wr0 = wr_tot;
        do_cmd(1'b1, 8'h40, 8'd0);
        for (int c = 1; c <= 4; c++) begin
            cmd_valid = (c == 2);
            cmd_write = 1'b0;
            cmd_addr  = 8'h80;
            cmd_len   = 8'd5;
            @(negedge clk);
            check("t5_cmd_ready_busy", 32'(cmd_ready), 32'd0);
            check("t5_busy", 32'(busy), 32'd1);
            check("t5_no_access", 32'(mem_enable), 32'd0);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        wr_valid  = 1'b1;
        wr_data   = 32'h5A5A_0040;
        ref_mem[8'h40] = 32'h5A5A_0040;
        @(negedge clk);
        check("t5_en_wr", 32'({mem_enable, mem_write}), 32'h0000_00FF);
        check("t5_address", 32'(mem_address), 32'h40);
        check("t5_datain", mem_datain, 32'h5A5A_0040);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        @(negedge clk);
        check("t5_done_cycle6", 32'(done), 32'd1);
        check("t5_busy_end", 32'(busy), 32'd0);
        check("t5_one_write", 32'(wr_tot - wr0), 32'd1);
        check("t5_sram_word", sram[8'h40], 32'h5A5A_0040);
        @(posedge clk); #1;
        @(negedge clk);
        check("t5_done_pulse", 32'(done), 32'd0);
        check("t5_ignored_cmd", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // 6. Reset after two of eight words have been read
        write_burst(8'h60, 8'd7, 32'hD000_0000);
        do_cmd(1'b0, 8'h60, 8'd7);
        rd_ready = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 4) begin
                check("t6_second_word", rd_data, 32'hD000_0001);
                check("t6_second_valid", 32'(rd_valid), 32'd1);
            end
            @(posedge clk); #1;
        end
        check("t6_busy_before_rst", 32'(busy), 32'd1);
        rstn = 1'b0;
        #1;
        check_reset_vals("t6_async");
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("t6_en_in_reset", 32'(mem_enable), 32'd0);
            check("t6_done_in_reset", 32'(done), 32'd0);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        rd_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t6_no_done", 32'(done), 32'd0);
            check("t6_idle_after", 32'(busy), 32'd0);
        end
        @(posedge clk); #1;
        read_burst(8'h62, 8'd2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
